inst_queue: RTL and testbench

- Instruction queue between the fetch stage and decode/rename.
- Buffers fetched pipe_in_t entries (pc, instruction, prediction, branch, jump) in program order.
- Back-pressures fetch via `full`, which fetch uses as its stall/enable source.
- Discards all contents on a pipeline flush (branch mispredict or jump redirect at commit).

---
 rtl/inst_queue_pkg.sv | 16 +
 rtl/inst_queue.sv | 63 ++++++
 tb/tb_inst_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode types for the instruction queue.
//   pipe_in_t : one fetched entry (67 bits), passed through the queue unmodified.
//   IQ_DEPTH  : default queue depth.
package inst_queue_pkg;

  localparam int unsigned IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        prediction;
    logic        branch;
    logic        jump;
  } pipe_in_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode/rename. Holds fetched entries in
// program order, stalls fetch through `full`, and drops everything on a flush.
//   clk, reset (sync, active-high), flush : control
//   push_valid, pipe_in, full             : fetch side
//   out_valid, pipe_out, pop_ready        : decode side
//   count                                 : occupancy, 0..DEPTH
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_valid,
  input  pipe_in_t         pipe_in,
  output logic             full,
  output logic             out_valid,
  output pipe_in_t         pipe_out,
  input  logic             pop_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  pipe_in_t             mem_q [DEPTH];
  logic     [PTR_W-1:0] wr_ptr_q;
  logic     [PTR_W-1:0] rd_ptr_q;
  logic     [PTR_W:0]   count_q;
  logic                 push;
  logic                 pop;

  // Flags come only from registered state: a pop while full does not open a
  // slot for a same-cycle push, so fetch must hold its entry.
  always_comb begin
    full      = (count_q == FullCount);
    out_valid = (count_q != '0);
    push      = push_valid & ~full;
    pop       = pop_ready & out_valid;
    pipe_out  = mem_q[rd_ptr_q];
    count     = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // Storage is left as-is; only pointers and occupancy are cleared.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= pipe_in;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     flush;
  logic     push_valid;
  pipe_in_t pipe_in;
  logic     full;
  logic     out_valid;
  pipe_in_t pipe_out;
  logic     pop_ready;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  pipe_in_t exp_q[$];

  inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (push_valid),
    .pipe_in    (pipe_in),
    .full       (full),
    .out_valid  (out_valid),
    .pipe_out   (pipe_out),
    .pop_ready  (pop_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic pipe_in_t mk(input logic [31:0] pc);
    pipe_in_t e;
    e.pc          = pc;
    e.instruction = {pc[15:0], ~pc[15:0]};
    e.prediction  = pc[2];
    e.branch      = pc[3];
    e.jump        = pc[4];
    return e;
  endfunction

  // One ordinary cycle (no reset/flush); reference queue tracks accepted traffic.
  task automatic cyc(input logic pv, input logic pr, input logic [31:0] pc);
    bit do_push, do_pop;
    push_valid = pv;
    pop_ready  = pr;
    pipe_in    = mk(pc);
    do_push    = pv && (exp_q.size() < 8);
    do_pop     = pr && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(mk(pc));
    push_valid = 1'b0;
    pop_ready  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 67'(count), 67'(exp_q.size()));
    check({tag, ".full"}, 67'(full), 67'(exp_q.size() == 8));
    check({tag, ".out_valid"}, 67'(out_valid), 67'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, ".pipe_out"}, pipe_out, exp_q[0]);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; pipe_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.count", 67'(count), 67'd0);
    check("rst.full", 67'(full), 67'd0);
    check("rst.out_valid", 67'(out_valid), 67'd0);

    // Fill with pc 0x00..0x1C, then a dropped 9th push.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 32'(i * 4));
      check_state("fill");
    end
    check("fill.full8", 67'(full), 67'd1);
    check("fill.count8", 67'(count), 67'd8);
    cyc(1'b1, 1'b0, 32'h20);
    check("drop9.count", 67'(count), 67'd8);
    check("drop9.full", 67'(full), 67'd1);

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      check("drain.pc", 67'(pipe_out.pc), 67'(i * 4));
      cyc(1'b0, 1'b1, 32'h0);
    end
    check("drain.out_valid", 67'(out_valid), 67'd0);
    check("drain.count", 67'(count), 67'd0);

    // Pop on empty is ignored.
    cyc(1'b0, 1'b1, 32'h0);
    check("empty_pop.count", 67'(count), 67'd0);

    // Concurrent push/pop at count 3, pointers wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h40 + 32'(i * 4));
    for (int i = 0; i < 10; i++) begin
      check("conc.pc", 67'(pipe_out.pc), 67'(32'h40 + 32'(i * 4)));
      cyc(1'b1, 1'b1, 32'h4C + 32'(i * 4));
      check("conc.count", 67'(count), 67'd3);
    end
    check_state("conc_end");

    // Full plus pop: pop taken, push dropped.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h80 + 32'(i * 4));
    check("fullpop.pre", 67'(count), 67'd8);
    cyc(1'b1, 1'b1, 32'hF0);
    check("fullpop.count", 67'(count), 67'd7);
    check("fullpop.full", 67'(full), 67'd0);
    check_state("fullpop");

    // Flush at count 5 with push and pop active.
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 32'h0);
    check("flush.pre", 67'(count), 67'd5);
    flush = 1'b1; push_valid = 1'b1; pop_ready = 1'b1; pipe_in = mk(32'hF4);
    @(posedge clk);
    #1;
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    exp_q.delete();
    check("flush.count", 67'(count), 67'd0);
    check("flush.out_valid", 67'(out_valid), 67'd0);
    check("flush.full", 67'(full), 67'd0);
    cyc(1'b1, 1'b0, 32'h100);
    check("flush.next", pipe_out, mk(32'h100));
    check_state("post_flush");

    // Reset mid-operation at count 4.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h104 + 32'(i * 4));
    check("rst2.pre", 67'(count), 67'd4);
    reset = 1'b1; push_valid = 1'b1; pipe_in = mk(32'h1F0);
    @(posedge clk);
    #1;
    reset = 1'b0; push_valid = 1'b0;
    exp_q.delete();
    check("rst2.count", 67'(count), 67'd0);
    check("rst2.full", 67'(full), 67'd0);
    check("rst2.out_valid", 67'(out_valid), 67'd0);

    // Push into empty with pop_ready high: no pop, count becomes 1.
    cyc(1'b1, 1'b1, 32'h200);
    check("rst2.push.count", 67'(count), 67'd1);
    check("rst2.push.data", pipe_out, mk(32'h200));
    cyc(1'b1, 1'b0, 32'h204);
    cyc(1'b0, 1'b1, 32'h0);
    check("rst2.pop.pc", 67'(pipe_out.pc), 67'h204);
    check_state("rst2.pop");
    cyc(1'b0, 1'b1, 32'h0);
    check("rst2.empty", 67'(count), 67'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
